// File: rtl/commit_trace_tx.sv
// commit_trace_tx: packs per-cycle commit events into trace records, queues them and sends them over valid/ready
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   reg_wr, wr_reg, wr_data         WB register-file write tap
//   mem_rd, mem_wr, mem_addr,
//   mem_wdata, mem_rdata            completed memory-stage access tap
//   halt                            halt reached memory stage
//   icache_*/dcache_* req/hit       cache statistic strobes
//   trace_valid, trace_ready,
//   trace_rec                       record link {halt,mem_wr,mem_rd,reg_wr,wr_reg,wr_data,mem_addr,mdata}
//   trace_stall, overflow, done     flow status
//   cycle_cnt .. dc_hit_cnt         statistics counters
module commit_trace_tx #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             reg_wr,
   input  logic [2:0]       wr_reg,
   input  logic [15:0]      wr_data,
   input  logic             mem_rd,
   input  logic             mem_wr,
   input  logic [15:0]      mem_addr,
   input  logic [15:0]      mem_wdata,
   input  logic [15:0]      mem_rdata,
   input  logic             halt,
   input  logic             icache_req,
   input  logic             icache_hit,
   input  logic             dcache_req,
   input  logic             dcache_hit,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [54:0]      trace_rec,
   output logic             trace_stall,
   output logic             overflow,
   output logic             done,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] inst_cnt,
   output logic [CNT_W-1:0] ic_req_cnt,
   output logic [CNT_W-1:0] ic_hit_cnt,
   output logic [CNT_W-1:0] dc_req_cnt,
   output logic [CNT_W-1:0] dc_hit_cnt
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {RUN, DRAIN, FIN} state_t;
   state_t state, state_nx;
   logic [54:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count, count_nx;
   logic ev, pop, full, push, drop, run;
   logic [54:0] rec;
   logic [15:0] mdata;
   always_comb begin
      run = state == RUN;
      ev = run && (reg_wr | mem_rd | mem_wr | halt);
      pop = trace_valid & trace_ready;
      full = count == (AW+1)'(DEPTH);
      // a simultaneous pop frees the slot, so a full FIFO still accepts
      push = ev & (~full | pop);
      drop = ev & full & ~pop;
      count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
      mdata = mem_wr ? mem_wdata : mem_rd ? mem_rdata : 16'd0;
      rec = {halt, mem_wr, mem_rd, reg_wr,
             reg_wr ? wr_reg : 3'd0,
             reg_wr ? wr_data : 16'd0,
             (mem_rd | mem_wr) ? mem_addr : 16'd0,
             mdata};
      state_nx = (run && ev && halt) ? DRAIN :
                 (state == DRAIN && count == '0) ? FIN : state;
   end
   assign trace_valid = state != FIN && count != '0;
   assign trace_rec = trace_valid ? mem[rd_ptr] : '0;
   assign done = state == FIN;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= rec;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         trace_stall <= 1'b0;
         overflow <= 1'b0;
         cycle_cnt <= '0;
         inst_cnt <= '0;
         ic_req_cnt <= '0;
         ic_hit_cnt <= '0;
         dc_req_cnt <= '0;
         dc_hit_cnt <= '0;
      end else begin
         state <= state_nx;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count_nx;
         trace_stall <= count_nx >= (AW+1)'(DEPTH-1);
         overflow <= overflow | drop;
         if (run) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            inst_cnt <= inst_cnt + CNT_W'(reg_wr | mem_wr | halt);
            ic_req_cnt <= ic_req_cnt + CNT_W'(icache_req);
            ic_hit_cnt <= ic_hit_cnt + CNT_W'(icache_hit);
            dc_req_cnt <= dc_req_cnt + CNT_W'(dcache_req);
            dc_hit_cnt <= dc_hit_cnt + CNT_W'(dcache_hit);
         end
      end
   end
endmodule

// File: tb/tb_commit_trace_tx.sv
// tb_commit_trace_tx: directed and randomized checks of commit_trace_tx against a queue-based model
module tb_commit_trace_tx;
   localparam int DEPTH = 8;
   typedef logic [54:0] rec_t;
   logic clk = 0, rst = 0;
   logic reg_wr = 0, mem_rd = 0, mem_wr = 0, halt = 0, trace_ready = 0;
   logic icache_req = 0, icache_hit = 0, dcache_req = 0, dcache_hit = 0;
   logic [2:0] wr_reg = 0;
   logic [15:0] wr_data = 0, mem_addr = 0, mem_wdata = 0, mem_rdata = 0;
   logic trace_valid, trace_stall, overflow, done;
   logic [54:0] trace_rec;
   logic [31:0] cycle_cnt, inst_cnt, ic_req_cnt, ic_hit_cnt, dc_req_cnt, dc_hit_cnt;
   rec_t q[$];
   rec_t sent[$];
   logic m_ovf;
   logic [31:0] m_cyc, m_inst, m_icr, m_ich, m_dcr, m_dch;
   int m_ph;
   logic mv;
   int errs = 0, checks = 0;
   always #5 clk = ~clk;
   commit_trace_tx #(.DEPTH(DEPTH), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .reg_wr(reg_wr), .wr_reg(wr_reg), .wr_data(wr_data),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .halt(halt), .icache_req(icache_req), .icache_hit(icache_hit),
      .dcache_req(dcache_req), .dcache_hit(dcache_hit), .trace_valid(trace_valid),
      .trace_ready(trace_ready), .trace_rec(trace_rec), .trace_stall(trace_stall),
      .overflow(overflow), .done(done), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt),
      .ic_req_cnt(ic_req_cnt), .ic_hit_cnt(ic_hit_cnt), .dc_req_cnt(dc_req_cnt),
      .dc_hit_cnt(dc_hit_cnt));
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic mclear();
      q.delete();
      m_ovf = 0; m_ph = 0;
      m_cyc = 0; m_inst = 0; m_icr = 0; m_ich = 0; m_dcr = 0; m_dch = 0;
   endtask
   function automatic rec_t mk();
      rec_t r = '0;
      r[54] = halt; r[53] = mem_wr; r[52] = mem_rd; r[51] = reg_wr;
      if (reg_wr) begin r[50:48] = wr_reg; r[47:32] = wr_data; end
      if (mem_rd || mem_wr) r[31:16] = mem_addr;
      r[15:0] = mem_wr ? mem_wdata : mem_rd ? mem_rdata : 16'h0;
      return r;
   endfunction
   task automatic mstep();
      int n;
      bit p, ev;
      rec_t r;
      n = q.size();
      p = m_ph != 2 && n > 0 && trace_ready;
      ev = m_ph == 0 && (reg_wr || mem_rd || mem_wr || halt);
      r = mk();
      if (m_ph == 0) begin
         m_cyc++;
         if (reg_wr || mem_wr || halt) m_inst++;
         if (icache_req) m_icr++;
         if (icache_hit) m_ich++;
         if (dcache_req) m_dcr++;
         if (dcache_hit) m_dch++;
      end
      if (p) void'(q.pop_front());
      if (ev) begin
         if (n < DEPTH || p) q.push_back(r);
         else m_ovf = 1;
      end
      if (m_ph == 0 && ev && halt) m_ph = 1;
      else if (m_ph == 1 && n == 0) m_ph = 2;
   endtask
   task automatic cyc();
      @(posedge clk);
      if (rst) mclear(); else mstep();
      #1;
   endtask
   task automatic clr_in();
      reg_wr = 0; mem_rd = 0; mem_wr = 0; halt = 0; wr_reg = 0; wr_data = 0;
      mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
      icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
   endtask
   task automatic set_ev(logic r, logic [2:0] wrg, logic [15:0] wd, logic rd, logic w,
                         logic [15:0] a, logic [15:0] wdt, logic [15:0] rdt, logic h);
      reg_wr = r; wr_reg = wrg; wr_data = wd; mem_rd = rd; mem_wr = w;
      mem_addr = a; mem_wdata = wdt; mem_rdata = rdt; halt = h;
   endtask
   task automatic do_reset();
      rst = 1;
      mclear();
      cyc();
      cyc();
      rst = 0;
   endtask
   always @(negedge clk) begin
      mv = m_ph != 2 && q.size() > 0;
      chk("valid", trace_valid, mv);
      chk("rec", trace_rec, mv ? q[0] : rec_t'(0));
      chk("stall", trace_stall, q.size() >= DEPTH - 1);
      chk("overflow", overflow, m_ovf);
      chk("done", done, m_ph == 2);
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("inst_cnt", inst_cnt, m_inst);
      chk("ic_req_cnt", ic_req_cnt, m_icr);
      chk("ic_hit_cnt", ic_hit_cnt, m_ich);
      chk("dc_req_cnt", dc_req_cnt, m_dcr);
      chk("dc_hit_cnt", dc_hit_cnt, m_dch);
      if (trace_valid && trace_ready && !rst) sent.push_back(trace_rec);
   end
   initial begin
      mclear();
      rst = 1;
      #2;
      chk("reset_valid", trace_valid, 0);
      chk("reset_rec", trace_rec, 0);
      cyc();
      cyc();
      rst = 0;
      trace_ready = 1;
      set_ev(1, 3, 16'h1234, 0, 0, 0, 0, 0, 0);
      cyc();
      clr_in();
      @(negedge clk);
      chk("wr_rec", trace_rec, 55'h0B_1234_0000_0000);
      chk("wr_valid", trace_valid, 1);
      chk("wr_inst", inst_cnt, 1);
      cyc();
      trace_ready = 0;
      set_ev(1, 1, 16'hBEEF, 1, 0, 16'h0040, 0, 16'hBEEF, 0);
      cyc();
      clr_in();
      @(negedge clk);
      chk("ld_rec", trace_rec, 55'h19_BEEF_0040_BEEF);
      cyc();
      @(negedge clk);
      chk("ld_hold", trace_rec, 55'h19_BEEF_0040_BEEF);
      trace_ready = 1;
      cyc();
      cyc();
      trace_ready = 0;
      for (int i = 0; i < 5; i++) begin
         set_ev(1, 3'(i), 16'hC000 + 16'(i), 0, 0, 0, 0, 0, 0);
         cyc();
      end
      clr_in();
      rst = 1;
      mclear();
      #1;
      chk("rst_valid", trace_valid, 0);
      chk("rst_inst", inst_cnt, 0);
      chk("rst_cycle", cycle_cnt, 0);
      cyc();
      rst = 0;
      cyc();
      for (int i = 0; i < 8; i++) begin
         set_ev(1, 3'(i), 16'hA000 + 16'(i), 0, 0, 0, 0, 0, 0);
         cyc();
         if (i == 5) chk("stall_6", trace_stall, 0);
         if (i == 6) chk("stall_7", trace_stall, 1);
      end
      trace_ready = 1;
      set_ev(1, 0, 16'hA008, 0, 0, 0, 0, 0, 0);
      cyc();
      trace_ready = 0;
      chk("fpp_ovf", overflow, 0);
      chk("fpp_stall", trace_stall, 1);
      set_ev(1, 1, 16'hA009, 0, 0, 0, 0, 0, 0);
      cyc();
      clr_in();
      chk("drop_ovf", overflow, 1);
      chk("drop_inst", inst_cnt, 10);
      chk("head_after_pop", trace_rec[47:32], 16'hA001);
      trace_ready = 1;
      repeat (10) cyc();
      do_reset();
      sent.delete();
      trace_ready = 1;
      for (int i = 0; i < 3; i++) begin
         set_ev(0, 0, 0, 0, 1, 16'h0100 + 16'(i), 16'h5500 + 16'(i), 0, 0);
         cyc();
      end
      set_ev(0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc();
      clr_in();
      for (int k = 0; k < 50 && !done; k++) cyc();
      chk("halt_done", done, 1);
      chk("halt_sent", sent.size(), 4);
      chk("halt_flag", sent.size() == 4 ? sent[3][54] : 1'b0, 1);
      repeat (5) cyc();
      chk("halt_cycle_frozen", cycle_cnt, 4);
      chk("halt_valid", trace_valid, 0);
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reg_wr = $urandom_range(0, 1);
         wr_reg = 3'($urandom);
         wr_data = 16'($urandom);
         mem_rd = $urandom_range(0, 3) == 0;
         mem_wr = $urandom_range(0, 3) == 0;
         mem_addr = 16'($urandom);
         mem_wdata = 16'($urandom);
         mem_rdata = 16'($urandom);
         halt = $urandom_range(0, 149) == 0;
         icache_req = $urandom_range(0, 1);
         icache_hit = $urandom_range(0, 1);
         dcache_req = $urandom_range(0, 1);
         dcache_hit = $urandom_range(0, 1);
         trace_ready = ((c / 64) % 2 == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
         if (m_ph == 2 || $urandom_range(0, 399) == 0) begin
            clr_in();
            do_reset();
         end else cyc();
      end
      clr_in();
      repeat (3) cyc();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
